fir_mac_engine: RTL and testbench



---
 rtl/fir_mac_engine.sv | 158 +++++++++++++++
 tb/tb_fir_mac_engine.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mac_engine.sv
// Multi-channel FIR multiply-accumulate engine.
//
// A start pulse in IDLE walks N_TAPS coefficients from an external synchronous ROM
// and N_TAPS sample words from a sample queue. All channels share the coefficient
// stream. Each channel accumulates at full precision. The result is then rounded
// (optional), arithmetically shifted and saturated (optional) to DATA_W.
//
// Ports:
//   clk        system clock
//   rst        asynchronous, active-high reset
//   start      begin a computation (sampled only in IDLE)
//   clr        synchronous abort to IDLE; smpl_out keeps its value
//   coef_addr  coefficient ROM address; ROM data returns one clock later on coef_in
//   coef_in    signed coefficient from ROM
//   smpl_req   sample request; the queue presents smpl_in one clock later
//   smpl_in    packed signed samples, channel c at [c*DATA_W +: DATA_W]
//   smpl_out   packed filtered samples, same packing, held between updates
//   busy       high whenever the engine is not IDLE
//   done       one-cycle pulse, coincident with a new smpl_out
module fir_mac_engine #(
    parameter int unsigned N_CH      = 2,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned N_TAPS    = 1021,
    parameter int unsigned ACC_W     = 40,
    parameter int unsigned OUT_SHIFT = 15,
    parameter int unsigned RND_EN    = 1,
    parameter int unsigned SAT_EN    = 1,
    localparam int unsigned ADDR_W   = (N_TAPS > 1) ? $clog2(N_TAPS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   clr,
    output logic [ADDR_W-1:0]      coef_addr,
    input  logic [COEF_W-1:0]      coef_in,
    output logic                   smpl_req,
    input  logic [N_CH*DATA_W-1:0] smpl_in,
    output logic [N_CH*DATA_W-1:0] smpl_out,
    output logic                   busy,
    output logic                   done
);

    localparam int unsigned PROD_W = DATA_W + COEF_W;
    localparam logic [ADDR_W-1:0] LAST_TAP = ADDR_W'(N_TAPS - 1);
    localparam logic signed [ACC_W:0] RND_ADD =
        (RND_EN != 0) ? ((ACC_W + 1)'(1) << (OUT_SHIFT - 1)) : '0;
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W - DATA_W + 2){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W - DATA_W + 2){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StOut} state_e;

    state_e                   state_q;
    logic [ADDR_W-1:0]        tap_q;
    logic                     issue_q;
    logic                     acc_clr;
    logic signed [ACC_W-1:0]  acc_q [N_CH];
    logic signed [PROD_W-1:0] prod [N_CH];
    logic signed [ACC_W:0]    rnd_acc;
    logic signed [ACC_W:0]    shifted;
    logic [N_CH*DATA_W-1:0]   out_d;

    assign busy    = (state_q != StIdle);
    assign acc_clr = (state_q == StIdle) && start && !clr;

    // Control FSM; outputs are registered so coef_addr/smpl_req lead the data by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tap_q     <= '0;
            coef_addr <= '0;
            smpl_req  <= 1'b0;
            issue_q   <= 1'b0;
            done      <= 1'b0;
            smpl_out  <= '0;
        end else begin
            done    <= 1'b0;
            issue_q <= smpl_req;
            if (clr) begin
                state_q   <= StIdle;
                tap_q     <= '0;
                coef_addr <= '0;
                smpl_req  <= 1'b0;
                issue_q   <= 1'b0;
            end else begin
                case (state_q)
                    StIdle: begin
                        if (start) begin
                            state_q   <= StRun;
                            tap_q     <= '0;
                            coef_addr <= '0;
                            smpl_req  <= 1'b1;
                        end
                    end
                    StRun: begin
                        if (tap_q == LAST_TAP) begin
                            state_q   <= StDrain;
                            coef_addr <= '0;
                            smpl_req  <= 1'b0;
                        end else begin
                            tap_q     <= tap_q + 1'b1;
                            coef_addr <= tap_q + 1'b1;
                        end
                    end
                    StDrain: state_q <= StOut;
                    StOut: begin
                        smpl_out <= out_d;
                        done     <= 1'b1;
                        state_q  <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    // Full-width signed products, one per channel, sharing the same coefficient.
    always_comb begin
        for (int c = 0; c < N_CH; c++) begin
            prod[c] = PROD_W'($signed(coef_in)) * PROD_W'($signed(smpl_in[c*DATA_W +: DATA_W]));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
        end else if (acc_clr) begin
            for (int c = 0; c < N_CH; c++) acc_q[c] <= '0;
        end else if (issue_q) begin
            for (int c = 0; c < N_CH; c++) acc_q[c] <= acc_q[c] + ACC_W'(prod[c]);
        end
    end

    // One extra bit keeps the rounding add from overflowing the accumulator range.
    always_comb begin
        out_d   = '0;
        rnd_acc = '0;
        shifted = '0;
        for (int c = 0; c < N_CH; c++) begin
            rnd_acc = (ACC_W + 1)'(acc_q[c]) + RND_ADD;
            shifted = rnd_acc >>> OUT_SHIFT;
            if (SAT_EN != 0) begin
                if (shifted > SAT_MAX) begin
                    out_d[c*DATA_W +: DATA_W] = SAT_MAX[DATA_W-1:0];
                end else if (shifted < SAT_MIN) begin
                    out_d[c*DATA_W +: DATA_W] = SAT_MIN[DATA_W-1:0];
                end else begin
                    out_d[c*DATA_W +: DATA_W] = shifted[DATA_W-1:0];
                end
            end else begin
                out_d[c*DATA_W +: DATA_W] = shifted[DATA_W-1:0];
            end
        end
    end

endmodule

// File: tb/tb_fir_mac_engine.sv
// Bench for fir_mac_engine. Instances a (round+saturate) and b (truncate+wrap) share
// one ROM, one sample memory and one control stream (2 channels, 4 taps). Instance c
// has 4 channels and a single tap.
module tb_fir_mac_engine;

    logic clk = 1'b0;
    logic rst;
    logic start_ab, clr_ab, start_c;

    logic [1:0]  coef_addr_a, coef_addr_b;
    logic [15:0] coef_in_a, coef_in_b;
    logic        smpl_req_a, smpl_req_b;
    logic [31:0] smpl_in_a, smpl_in_b, smpl_out_a, smpl_out_b;
    logic        busy_a, busy_b, done_a, done_b;

    logic [0:0]  coef_addr_c;
    logic [15:0] coef_in_c;
    logic        smpl_req_c;
    logic [63:0] smpl_in_c, smpl_out_c;
    logic        busy_c, done_c;

    logic [15:0] rom [4];
    logic [31:0] smem [4];
    logic [15:0] rom_c [2];
    logic [63:0] smem_c;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fir_mac_engine #(.N_CH(2), .DATA_W(16), .COEF_W(16), .N_TAPS(4), .ACC_W(40),
                     .OUT_SHIFT(15), .RND_EN(1), .SAT_EN(1)) u_a (
        .clk(clk), .rst(rst), .start(start_ab), .clr(clr_ab),
        .coef_addr(coef_addr_a), .coef_in(coef_in_a), .smpl_req(smpl_req_a),
        .smpl_in(smpl_in_a), .smpl_out(smpl_out_a), .busy(busy_a), .done(done_a));

    fir_mac_engine #(.N_CH(2), .DATA_W(16), .COEF_W(16), .N_TAPS(4), .ACC_W(40),
                     .OUT_SHIFT(15), .RND_EN(0), .SAT_EN(0)) u_b (
        .clk(clk), .rst(rst), .start(start_ab), .clr(clr_ab),
        .coef_addr(coef_addr_b), .coef_in(coef_in_b), .smpl_req(smpl_req_b),
        .smpl_in(smpl_in_b), .smpl_out(smpl_out_b), .busy(busy_b), .done(done_b));

    fir_mac_engine #(.N_CH(4), .DATA_W(16), .COEF_W(16), .N_TAPS(1), .ACC_W(40),
                     .OUT_SHIFT(15), .RND_EN(1), .SAT_EN(1)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .clr(1'b0),
        .coef_addr(coef_addr_c), .coef_in(coef_in_c), .smpl_req(smpl_req_c),
        .smpl_in(smpl_in_c), .smpl_out(smpl_out_c), .busy(busy_c), .done(done_c));

    // Synchronous ROM and sample queue models.
    always @(posedge clk) begin
        coef_in_a <= rom[coef_addr_a];
        coef_in_b <= rom[coef_addr_b];
        coef_in_c <= rom_c[coef_addr_c];
        if (smpl_req_a) smpl_in_a <= smem[coef_addr_a];
        if (smpl_req_b) smpl_in_b <= smem[coef_addr_b];
        if (smpl_req_c) smpl_in_c <= smem_c;
    end

    typedef struct packed {
        logic [3:0][15:0] coef;
        logic [3:0][15:0] s0;
        logic [3:0][15:0] s1;
        logic [15:0] ea0, ea1, eb0, eb1;
    } vec_t;

    vec_t vecs [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: exact sum of products, then round/shift/saturate with plain integers.
    function automatic longint acc_ref(input int ch);
        longint a = 0;
        for (int k = 0; k < 4; k++)
            a += longint'($signed(rom[k])) * longint'($signed(smem[k][ch*16 +: 16]));
        return a;
    endfunction

    function automatic logic [15:0] post(input longint acc, input bit rnd, input bit sat);
        longint r;
        r = acc + (rnd ? 64'sd16384 : 64'sd0);
        r = r >>> 15;
        if (sat && r > 32767) return 16'h7FFF;
        if (sat && r < -32768) return 16'h8000;
        return r[15:0];
    endfunction

    task automatic load_vec(input int i);
        for (int k = 0; k < 4; k++) begin
            rom[k]  = vecs[i].coef[k];
            smem[k] = {vecs[i].s1[k], vecs[i].s0[k]};
        end
    endtask

    // Pulses start; returns clocks from the start edge to the done cycle (bounded).
    task automatic run_ab(output int lat);
        @(negedge clk);
        start_ab = 1'b1;
        @(posedge clk);
        #1;
        start_ab = 1'b0;
        check("busy_after_start", busy_a, 1);
        lat = 0;
        while (!done_a && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("done_b_aligned", done_b, done_a);
    endtask

    task automatic run_c(output int lat);
        @(negedge clk);
        start_c = 1'b1;
        @(posedge clk);
        #1;
        start_c = 1'b0;
        lat = 0;
        while (!done_c && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int n;
        int dt [4];
        logic [31:0] prev_a, prev_b;

        vecs[0] = '{coef: {4{16'h4000}}, s0: {4{16'd1000}}, s1: {4{16'd1000}},
                    ea0: 16'd2000, ea1: 16'd2000, eb0: 16'd2000, eb1: 16'd2000};
        // 4*(2^15-1)^2 >> 15 = 131064 -> 0xFFF8 when wrapped; -4*(2^15-1)*2^15 >> 15 = -131068
        vecs[1] = '{coef: {4{16'h7FFF}}, s0: {4{16'h7FFF}}, s1: {4{16'h8000}},
                    ea0: 16'h7FFF, ea1: 16'h8000, eb0: 16'hFFF8, eb1: 16'h0004};
        vecs[2] = '{coef: {16'h0, 16'h0, 16'h0, 16'h1}, s0: {4{16'h4000}}, s1: {4{16'hC000}},
                    ea0: 16'h0001, ea1: 16'h0000, eb0: 16'h0000, eb1: 16'hFFFF};
        // ch0: 50-100+100+100 = 150; ch1: -2.125 -> rounds to -2, truncates to -3
        vecs[3] = '{coef: {16'h1000, 16'h2000, 16'hC000, 16'h4000},
                    s0: {16'd800, 16'd400, 16'd200, 16'd100},
                    s1: {16'd1, 16'd7, 16'd5, 16'hFFFD},
                    ea0: 16'd150, ea1: 16'hFFFE, eb0: 16'd150, eb1: 16'hFFFD};

        rst = 1'b1; start_ab = 1'b0; clr_ab = 1'b0; start_c = 1'b0;
        for (int k = 0; k < 4; k++) begin rom[k] = '0; smem[k] = '0; end
        rom_c[0] = '0; rom_c[1] = '0; smem_c = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_coef_addr", coef_addr_a, 0);
        check("rst_smpl_req", smpl_req_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_done", done_a, 0);
        check("rst_smpl_out_a", smpl_out_a, 0);
        check("rst_smpl_out_c", smpl_out_c, 0);
        @(negedge clk);
        rst = 1'b0;

        // Table vectors.
        for (int i = 0; i < 4; i++) begin
            load_vec(i);
            run_ab(lat);
            check("latency_ab", lat, 6);
            check("vec_a_ch0", smpl_out_a[15:0], vecs[i].ea0);
            check("vec_a_ch1", smpl_out_a[31:16], vecs[i].ea1);
            check("vec_b_ch0", smpl_out_b[15:0], vecs[i].eb0);
            check("vec_b_ch1", smpl_out_b[31:16], vecs[i].eb1);
            @(posedge clk);
            #1;
            check("done_single_pulse", done_a, 0);
            check("idle_after_done", busy_a, 0);
        end

        // Single tap, four independent channels.
        rom_c[0] = 16'h7FFF;
        smem_c = {16'h0000, 16'h7FFF, 16'hFF9C, 16'h0064};
        run_c(lat);
        check("latency_c", lat, 3);
        check("c_ch0", smpl_out_c[15:0], 16'd100);
        check("c_ch1", smpl_out_c[31:16], 16'hFF9C);
        check("c_ch2", smpl_out_c[47:32], 16'h7FFE);
        check("c_ch3", smpl_out_c[63:48], 16'h0000);
        for (int it = 0; it < 6; it++) begin
            rom_c[0] = 16'($urandom);
            smem_c = {$urandom, $urandom};
            run_c(lat);
            for (int ch = 0; ch < 4; ch++)
                check("c_rand", smpl_out_c[ch*16 +: 16],
                      post(longint'($signed(rom_c[0])) * longint'($signed(smem_c[ch*16 +: 16])),
                           1'b1, 1'b1));
        end

        // Randomized vectors against the reference model.
        for (int it = 0; it < 24; it++) begin
            for (int k = 0; k < 4; k++) begin
                rom[k]  = (it % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 8191) - 4096);
                smem[k] = $urandom;
            end
            run_ab(lat);
            check("latency_rand", lat, 6);
            for (int ch = 0; ch < 2; ch++) begin
                check("rand_a", smpl_out_a[ch*16 +: 16], post(acc_ref(ch), 1'b1, 1'b1));
                check("rand_b", smpl_out_b[ch*16 +: 16], post(acc_ref(ch), 1'b0, 1'b0));
            end
        end

        // start held high: a result every N_TAPS+3 clocks.
        load_vec(0);
        @(negedge clk);
        start_ab = 1'b1;
        @(posedge clk);
        #1;
        n = 0;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(posedge clk);
            #1;
            if (done_a) begin
                if (n < 4) dt[n] = cyc;
                n++;
            end
        end
        @(negedge clk);
        start_ab = 1'b0;
        check("b2b_count", n, 3);
        check("b2b_done0", dt[0], 6);
        check("b2b_done1", dt[1], 13);
        check("b2b_done2", dt[2], 20);
        for (int i = 0; i < 20 && busy_a; i++) begin @(posedge clk); #1; end
        check("b2b_idle", busy_a, 0);

        // start pulsed again during RUN is dropped.
        load_vec(3);
        @(negedge clk); start_ab = 1'b1;
        @(negedge clk); start_ab = 1'b0;
        @(negedge clk); start_ab = 1'b1;
        @(negedge clk); start_ab = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #1;
            if (done_a) n++;
        end
        check("ignored_start_dones", n, 1);
        check("ignored_start_a", smpl_out_a, {vecs[3].ea1, vecs[3].ea0});

        // clr and start together in IDLE: stays IDLE.
        @(negedge clk); start_ab = 1'b1; clr_ab = 1'b1;
        @(posedge clk); #1;
        check("clr_start_idle", busy_a, 0);
        @(negedge clk); start_ab = 1'b0; clr_ab = 1'b0;

        // clr while tap 2 is issued: abort, no done, outputs held.
        load_vec(0);
        prev_a = smpl_out_a;
        prev_b = smpl_out_b;
        @(negedge clk); start_ab = 1'b1;
        @(posedge clk); #1; start_ab = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("clr_at_tap2", coef_addr_a, 2);
        @(negedge clk); clr_ab = 1'b1;
        @(posedge clk); #1;
        check("clr_busy", busy_a, 0);
        check("clr_smpl_req", smpl_req_a, 0);
        @(negedge clk); clr_ab = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done_a) n++;
        end
        check("clr_no_done", n, 0);
        check("clr_hold_a", smpl_out_a, prev_a);
        check("clr_hold_b", smpl_out_b, prev_b);

        // rst mid-RUN clears everything at once; the next start computes correctly.
        @(negedge clk); start_ab = 1'b1;
        @(posedge clk); #1; start_ab = 1'b0;
        @(posedge clk);
        @(negedge clk); rst = 1'b1;
        #1;
        check("rst_mid_out", smpl_out_a, 0);
        check("rst_mid_busy", busy_a, 0);
        check("rst_mid_req", smpl_req_a, 0);
        @(negedge clk); rst = 1'b0;
        run_ab(lat);
        check("post_rst_latency", lat, 6);
        check("post_rst_a", smpl_out_a, {vecs[0].ea1, vecs[0].ea0});
        check("post_rst_b", smpl_out_b, {vecs[0].eb1, vecs[0].eb0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
